// File: rtl/obstacle_alert_arbiter.sv
`timescale 1ns / 1ps
// N-channel obstacle-alert arbiter: synchronise and debounce each sensor, pick one owner with sticky
// priority, hold its warning for a dwell after clearing, and drive it steady or blinking.
module obstacle_alert_arbiter #(
  parameter int N_CH       = 3,
  parameter int DEBOUNCE   = 4,
  parameter int HOLD       = 8,
  parameter int BLINK_HALF = 16,
  parameter int CW         = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [N_CH-1:0] sensor_in,
  input  logic            mode,
  output logic [N_CH-1:0] warn_out,
  output logic [CW-1:0]   active_ch,
  output logic            busy,
  output logic            switch_pulse
);

  typedef enum logic [1:0] {StIdle, StAlert, StHold} state_e;

  logic [N_CH-1:0] r_sync1, r_sync2, r_deb;
  logic [7:0]      r_dcnt [N_CH];

  state_e          r_state, w_state_d;
  logic [CW-1:0]   r_owner, w_owner_d, w_pick;
  logic [7:0]      r_timer, w_timer_d;
  logic [15:0]     r_blink_cnt, w_blink_cnt_d;
  logic            r_phase, w_phase_d;
  logic            w_any, w_owner_deb, w_switch, w_reload, w_busy_d;
  logic [N_CH-1:0] w_warn_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < N_CH; i++) r_dcnt[i] <= '0;
    end else begin
      r_sync1 <= sensor_in;
      r_sync2 <= r_sync1;
      for (int i = 0; i < N_CH; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_dcnt[i] == 8'(DEBOUNCE - 1)) begin
            r_deb[i]  <= r_sync2[i];
            r_dcnt[i] <= '0;
          end else begin
            r_dcnt[i] <= r_dcnt[i] + 8'd1;
          end
        end else begin
          r_dcnt[i] <= '0;
        end
      end
    end
  end

  // Lowest active index wins.
  always_comb begin
    w_pick = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (r_deb[i]) w_pick = CW'(i);
    end
  end

  assign w_any       = |r_deb;
  assign w_owner_deb = r_deb[r_owner];

  always_comb begin
    w_state_d = r_state;
    w_owner_d = r_owner;
    w_timer_d = r_timer;
    w_switch  = 1'b0;
    w_reload  = 1'b0;
    if (!ena) begin
      w_state_d = StIdle;
      w_owner_d = '0;
      w_timer_d = '0;
      w_switch  = (r_state != StIdle);
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            w_state_d = StAlert;
            w_owner_d = w_pick;
            w_switch  = 1'b1;
            w_reload  = 1'b1;
          end
        end
        StAlert: begin
          if (!w_owner_deb) begin
            if (w_any) begin
              w_owner_d = w_pick;
              w_switch  = 1'b1;
              w_reload  = 1'b1;
            end else if (HOLD > 0) begin
              w_state_d = StHold;
              w_timer_d = 8'(HOLD - 1);
            end else begin
              w_state_d = StIdle;
              w_owner_d = '0;
              w_switch  = 1'b1;
            end
          end
        end
        StHold: begin
          if (w_owner_deb) begin
            w_state_d = StAlert;
          end else if (w_any) begin
            w_state_d = StAlert;
            w_owner_d = w_pick;
            w_switch  = 1'b1;
            w_reload  = 1'b1;
          end else if (r_timer == '0) begin
            w_state_d = StIdle;
            w_owner_d = '0;
            w_switch  = 1'b1;
          end else begin
            w_timer_d = r_timer - 8'd1;
          end
        end
        default: begin
          w_state_d = StIdle;
          w_owner_d = '0;
          w_timer_d = '0;
        end
      endcase
    end
  end

  assign w_busy_d = (w_state_d != StIdle);

  // A fresh owner always starts on a full on-half.
  always_comb begin
    w_blink_cnt_d = r_blink_cnt + 16'd1;
    w_phase_d     = r_phase;
    if (!w_busy_d || w_reload) begin
      w_blink_cnt_d = '0;
      w_phase_d     = 1'b1;
    end else if (r_blink_cnt == 16'(BLINK_HALF - 1)) begin
      w_blink_cnt_d = '0;
      w_phase_d     = ~r_phase;
    end
  end

  always_comb begin
    w_warn_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_warn_d[i] = w_busy_d && (w_owner_d == CW'(i)) && (mode ? w_phase_d : 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_owner      <= '0;
      r_timer      <= '0;
      r_blink_cnt  <= '0;
      r_phase      <= 1'b1;
      warn_out     <= '0;
      active_ch    <= '0;
      busy         <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_owner      <= w_owner_d;
      r_timer      <= w_timer_d;
      r_blink_cnt  <= w_blink_cnt_d;
      r_phase      <= w_phase_d;
      warn_out     <= w_warn_d;
      active_ch    <= w_busy_d ? w_owner_d : '0;
      busy         <= w_busy_d;
      switch_pulse <= w_switch;
    end
  end

endmodule

// File: tb/tb_obstacle_alert_arbiter.sv
`timescale 1ns / 1ps
// Bench for obstacle_alert_arbiter: table of single-shot rise/release vectors plus hand sequences,
// with expected outputs queued per cycle and compared at the falling edge.
module tb_obstacle_alert_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [2:0] sensor_in;
  logic       mode;
  logic [2:0] warn_out;
  logic [1:0] active_ch;
  logic       busy;
  logic       switch_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    string      name;
    logic [2:0] warn;
    logic [1:0] ach;
    logic       busy;
    logic       pulse;
  } exp_t;

  typedef struct {
    logic [2:0] sens;
    logic [2:0] warn;
    logic [1:0] ach;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];

  obstacle_alert_arbiter #(
    .N_CH(3), .DEBOUNCE(4), .HOLD(8), .BLINK_HALF(16), .CW(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sensor_in(sensor_in), .mode(mode),
    .warn_out(warn_out), .active_ch(active_ch), .busy(busy), .switch_pulse(switch_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [2:0] ew, input logic [1:0] ea,
                       input logic eb, input logic ep);
    n_checks++;
    if (warn_out !== ew || active_ch !== ea || busy !== eb || switch_pulse !== ep) begin
      n_errors++;
      $display("FAIL %s @cyc%0d: got warn=%b ch=%0d busy=%b pulse=%b, want warn=%b ch=%0d busy=%b pulse=%b",
               name, cyc, warn_out, active_ch, busy, switch_pulse, ew, ea, eb, ep);
    end
  endtask

  task automatic expect_at(input int c, input string name, input logic [2:0] w,
                           input logic [1:0] a, input logic b, input logic p);
    exp_t e;
    int   idx;
    e.cyc = c; e.name = name; e.warn = w; e.ach = a; e.busy = b; e.pulse = p;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > c) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  // Leaves us at the falling edge just before edge k of a sequence whose edge 0 lands on cyc=base.
  task automatic goto_edge(input int base, input int k);
    while (cyc < base + k - 1) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check(e.name, e.warn, e.ach, e.busy, e.pulse);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, c, d;
    vecs[0] = '{3'b001, 3'b001, 2'd0};
    vecs[1] = '{3'b010, 3'b010, 2'd1};
    vecs[2] = '{3'b100, 3'b100, 2'd2};
    vecs[3] = '{3'b011, 3'b001, 2'd0};
    vecs[4] = '{3'b110, 3'b010, 2'd1};
    vecs[5] = '{3'b101, 3'b001, 2'd0};
    vecs[6] = '{3'b111, 3'b001, 2'd0};

    rst_n = 1'b0; ena = 1'b1; mode = 1'b0; sensor_in = '0;
    repeat (3) begin
      @(negedge clk);
      check("reset_zero", 3'b000, 2'd0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Rise from idle: latency 6, lowest index wins; release: dwell of 8 then idle pulse.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a = cyc + 1;
      sensor_in = vecs[i].sens;
      expect_at(a + 5, $sformatf("vec%0d_pre", i), 3'b000, 2'd0, 1'b0, 1'b0);
      expect_at(a + 6, $sformatf("vec%0d_rise", i), vecs[i].warn, vecs[i].ach, 1'b1, 1'b1);
      expect_at(a + 7, $sformatf("vec%0d_hold", i), vecs[i].warn, vecs[i].ach, 1'b1, 1'b0);
      goto_edge(a, 10);
      b = cyc + 1;
      sensor_in = '0;
      expect_at(b + 13, $sformatf("vec%0d_dwell", i), vecs[i].warn, vecs[i].ach, 1'b1, 1'b0);
      expect_at(b + 14, $sformatf("vec%0d_drop", i), 3'b000, 2'd0, 1'b0, 1'b1);
      expect_at(b + 15, $sformatf("vec%0d_idle", i), 3'b000, 2'd0, 1'b0, 1'b0);
      goto_edge(b, 16);
    end

    // Glitch of 3 cycles rejected; 4-cycle pulse accepted.
    @(negedge clk);
    a = cyc + 1;
    sensor_in = 3'b001;
    expect_at(a + 6, "glitch3_e6", 3'b000, 2'd0, 1'b0, 1'b0);
    expect_at(a + 8, "glitch3_e8", 3'b000, 2'd0, 1'b0, 1'b0);
    goto_edge(a, 3);
    sensor_in = '0;
    goto_edge(a, 12);
    b = cyc + 1;
    sensor_in = 3'b001;
    expect_at(b + 5, "pulse4_pre", 3'b000, 2'd0, 1'b0, 1'b0);
    expect_at(b + 6, "pulse4_rise", 3'b001, 2'd0, 1'b1, 1'b1);
    goto_edge(b, 4);
    sensor_in = '0;
    expect_at(b + 17, "pulse4_dwell", 3'b001, 2'd0, 1'b1, 1'b0);
    expect_at(b + 18, "pulse4_drop", 3'b000, 2'd0, 1'b0, 1'b1);
    goto_edge(b, 20);

    // Sticky priority, then switch with no dwell.
    a = cyc + 1;
    sensor_in = 3'b100;
    expect_at(a + 6, "sticky_own2", 3'b100, 2'd2, 1'b1, 1'b1);
    goto_edge(a, 8);
    b = cyc + 1;
    sensor_in = 3'b101;
    expect_at(b + 6, "sticky_keep_a", 3'b100, 2'd2, 1'b1, 1'b0);
    expect_at(b + 8, "sticky_keep_b", 3'b100, 2'd2, 1'b1, 1'b0);
    goto_edge(b, 10);
    c = cyc + 1;
    sensor_in = 3'b001;
    expect_at(c + 5, "switch_pre", 3'b100, 2'd2, 1'b1, 1'b0);
    expect_at(c + 6, "switch_to0", 3'b001, 2'd0, 1'b1, 1'b1);
    expect_at(c + 7, "switch_post", 3'b001, 2'd0, 1'b1, 1'b0);
    goto_edge(c, 10);
    d = cyc + 1;
    sensor_in = '0;
    expect_at(d + 13, "switch_dwell", 3'b001, 2'd0, 1'b1, 1'b0);
    expect_at(d + 14, "switch_idle", 3'b000, 2'd0, 1'b0, 1'b1);
    goto_edge(d, 16);

    // Re-assert during the dwell: back to ALERT with no pulse, dwell restarts on next drop.
    a = cyc + 1;
    sensor_in = 3'b010;
    expect_at(a + 6, "rehold_rise", 3'b010, 2'd1, 1'b1, 1'b1);
    goto_edge(a, 10);
    b = cyc + 1;
    sensor_in = '0;
    expect_at(b + 6, "rehold_h6", 3'b010, 2'd1, 1'b1, 1'b0);
    expect_at(b + 9, "rehold_h9", 3'b010, 2'd1, 1'b1, 1'b0);
    expect_at(b + 10, "rehold_back", 3'b010, 2'd1, 1'b1, 1'b0);
    expect_at(b + 14, "rehold_stay", 3'b010, 2'd1, 1'b1, 1'b0);
    goto_edge(b, 4);
    sensor_in = 3'b010;
    goto_edge(b, 16);
    d = cyc + 1;
    sensor_in = '0;
    expect_at(d + 13, "rehold_dwell", 3'b010, 2'd1, 1'b1, 1'b0);
    expect_at(d + 14, "rehold_idle", 3'b000, 2'd0, 1'b0, 1'b1);
    goto_edge(d, 16);

    // Blink: 16 on / 16 off; owner change mid-off restarts a full on-half.
    mode = 1'b1;
    @(negedge clk);
    a = cyc + 1;
    sensor_in = 3'b001;
    expect_at(a + 6, "blink_on0", 3'b001, 2'd0, 1'b1, 1'b1);
    expect_at(a + 21, "blink_on15", 3'b001, 2'd0, 1'b1, 1'b0);
    expect_at(a + 22, "blink_off0", 3'b000, 2'd0, 1'b1, 1'b0);
    expect_at(a + 25, "blink_off3", 3'b000, 2'd0, 1'b1, 1'b0);
    expect_at(a + 26, "blink_switch", 3'b010, 2'd1, 1'b1, 1'b1);
    expect_at(a + 41, "blink_sw_on15", 3'b010, 2'd1, 1'b1, 1'b0);
    expect_at(a + 42, "blink_sw_off", 3'b000, 2'd1, 1'b1, 1'b0);
    goto_edge(a, 7);
    sensor_in = 3'b011;
    goto_edge(a, 20);
    sensor_in = 3'b010;
    goto_edge(a, 43);
    mode = 1'b0;
    expect_at(a + 43, "mode_steady", 3'b010, 2'd1, 1'b1, 1'b0);
    goto_edge(a, 44);
    mode = 1'b1;
    expect_at(a + 44, "mode_phase_kept", 3'b000, 2'd1, 1'b1, 1'b0);
    goto_edge(a, 46);
    mode = 1'b0;
    c = cyc + 1;
    sensor_in = '0;
    expect_at(c + 14, "blink_idle", 3'b000, 2'd0, 1'b0, 1'b1);
    goto_edge(c, 16);

    // ena low while busy, re-enable with sensor held, then async reset mid-dwell.
    a = cyc + 1;
    sensor_in = 3'b100;
    expect_at(a + 6, "ena_rise", 3'b100, 2'd2, 1'b1, 1'b1);
    goto_edge(a, 10);
    ena = 1'b0;
    expect_at(a + 10, "ena_off", 3'b000, 2'd0, 1'b0, 1'b1);
    expect_at(a + 11, "ena_off_idle", 3'b000, 2'd0, 1'b0, 1'b0);
    goto_edge(a, 13);
    ena = 1'b1;
    expect_at(a + 13, "ena_on", 3'b100, 2'd2, 1'b1, 1'b1);
    expect_at(a + 14, "ena_on_post", 3'b100, 2'd2, 1'b1, 1'b0);
    goto_edge(a, 14);
    b = cyc + 1;
    sensor_in = '0;
    expect_at(b + 8, "rst_pre_dwell", 3'b100, 2'd2, 1'b1, 1'b0);
    goto_edge(b, 9);
    #2 rst_n = 1'b0;
    #1 check("rst_async", 3'b000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_held", 3'b000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    repeat (4) @(negedge clk);
    while (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: expectation for cyc%0d never reached", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
